// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - opcodes, policy encodings and FSM states shared by the cache level
package cache_pkg;

    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] OP_WRITE = 8'h57;

    localparam logic WP_WB   = 1'b0;
    localparam logic WP_WT   = 1'b1;
    localparam logic RP_FIFO = 1'b0;
    localparam logic RP_LRU  = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        RESP
    } cache_state_t;

endpackage

// File: rtl/cache_repl.sv
// rtl/cache_repl.sv - per-set LRU ages and FIFO pointers with victim-way selection
module cache_repl
    import cache_pkg::*;
#(
    parameter int SETS = 64,
    parameter int WAYS = 4,
    localparam int IDX_W = $clog2(SETS),
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             policy,
    input  logic [IDX_W-1:0] set_idx,
    input  logic [WAYS-1:0]  valid_set,
    output logic [WAY_W-1:0] victim_way,
    input  logic             touch,
    input  logic             fill,
    input  logic [WAY_W-1:0] way
);

    localparam logic [WAY_W-1:0] AGE_MAX = WAY_W'(WAYS - 1);

    logic [WAY_W-1:0] age [SETS][WAYS];
    logic [WAY_W-1:0] ptr [SETS];

    logic [WAY_W-1:0] lru_way;
    logic [WAY_W-1:0] max_age;
    logic [WAY_W-1:0] ref_age;
    logic             found_free;

    // Victim: lowest invalid way first, else oldest way (LRU) or the FIFO pointer.
    always_comb begin
        lru_way    = '0;
        found_free = 1'b0;
        max_age    = age[set_idx][0];
        for (int w = 1; w < WAYS; w++) begin
            if (age[set_idx][w] > max_age) begin
                max_age = age[set_idx][w];
                lru_way = WAY_W'(w);
            end
        end
        for (int w = 0; w < WAYS; w++) begin
            if (!found_free && !valid_set[w]) begin
                lru_way    = WAY_W'(w);
                found_free = 1'b1;
            end
        end
        victim_way = (policy == RP_LRU) ? lru_way : ptr[set_idx];
    end

    // Filling an empty way counts as touching the oldest slot, so every other way ages.
    assign ref_age = (fill && !valid_set[way]) ? AGE_MAX : age[set_idx][way];

    // Age and pointer update on a touch (hit) or fill (allocation).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < SETS; s++) begin
                ptr[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    age[s][w] <= '0;
                end
            end
        end else begin
            if (touch || fill) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (WAY_W'(w) == way) begin
                        age[set_idx][w] <= '0;
                    end else if (age[set_idx][w] < ref_age) begin
                        age[set_idx][w] <= age[set_idx][w] + 1'b1;
                    end
                end
            end
            if (fill) begin
                ptr[set_idx] <= (ptr[set_idx] == AGE_MAX) ? '0 : ptr[set_idx] + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cache_level.sv
// rtl/cache_level.sv - set-associative tag-only cache level with WB/WT and LRU/FIFO policies
module cache_level
    import cache_pkg::*;
#(
    parameter int ADDR_W      = 48,
    parameter int SETS        = 64,
    parameter int WAYS        = 4,
    parameter int BLOCK_BYTES = 64,
    parameter int CNT_W       = 12,
    localparam int OFF_W = $clog2(BLOCK_BYTES),
    localparam int IDX_W = $clog2(SETS),
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write_policy,
    input  logic              replace_policy,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [7:0]        req_op,
    output logic              rsp_valid,
    output logic              rsp_hit,
    output logic              rsp_err,
    output logic              mem_rd_valid,
    output logic [ADDR_W-1:0] mem_rd_addr,
    output logic              mem_wr_valid,
    output logic              wb_valid,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [CNT_W-1:0]  num_reads,
    output logic [CNT_W-1:0]  num_writes,
    output logic [CNT_W-1:0]  num_hits,
    output logic [CNT_W-1:0]  num_misses,
    output logic [CNT_W-1:0]  num_writebacks,
    output logic [TAG_W-1:0]  curr_tag,
    output logic [IDX_W-1:0]  curr_set
);

    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    cache_state_t state, state_nx;

    logic [TAG_W-1:0] tag_q;
    logic [IDX_W-1:0] idx_q;
    logic [7:0]       op_q;
    logic             wp_q;
    logic             rp_q;
    logic             hit_q;
    logic [WAY_W-1:0] hit_way_q;

    logic [TAG_W-1:0] tag_arr   [SETS][WAYS];
    logic [WAYS-1:0]  valid_arr [SETS];
    logic [WAYS-1:0]  dirty_arr [SETS];

    logic             accept;
    logic [WAYS-1:0]  hit_vec;
    logic [WAY_W-1:0] hit_enc;
    logic             is_rd, is_wr, op_err;
    logic             do_touch, do_fill, do_wb;
    logic [WAY_W-1:0] victim_way, upd_way;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;
    assign curr_tag  = tag_q;
    assign curr_set  = idx_q;

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // FSM next state: a fixed three-cycle walk per accepted request.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = LOOKUP;
            LOOKUP:  state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Parallel tag compare across all ways of the latched set.
    always_comb begin
        hit_vec = '0;
        hit_enc = '0;
        for (int w = 0; w < WAYS; w++) begin
            hit_vec[w] = valid_arr[idx_q][w] && (tag_arr[idx_q][w] == tag_q);
            if (hit_vec[w]) hit_enc = WAY_W'(w);
        end
    end

    // Response-phase decode: what the latched request does to the arrays.
    always_comb begin
        is_rd    = (op_q == OP_READ);
        is_wr    = (op_q == OP_WRITE);
        op_err   = !is_rd && !is_wr;
        do_touch = (state == RESP) && !op_err && hit_q;
        do_fill  = (state == RESP) && !hit_q && (is_rd || (is_wr && wp_q == WP_WB));
        upd_way  = hit_q ? hit_way_q : victim_way;
        do_wb    = do_fill && valid_arr[idx_q][victim_way] && dirty_arr[idx_q][victim_way];
    end

    cache_repl #(
        .SETS (SETS),
        .WAYS (WAYS)
    ) u_repl (
        .clk        (clk),
        .reset      (reset),
        .policy     (rp_q),
        .set_idx    (idx_q),
        .valid_set  (valid_arr[idx_q]),
        .victim_way (victim_way),
        .touch      (do_touch),
        .fill       (do_fill),
        .way        (upd_way)
    );

    // Latch the request and both policies at the handshake so later changes cannot affect it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_q <= '0;
            idx_q <= '0;
            op_q  <= '0;
            wp_q  <= WP_WB;
            rp_q  <= RP_FIFO;
        end else if (accept) begin
            tag_q <= req_addr[ADDR_W-1:IDX_W+OFF_W];
            idx_q <= req_addr[IDX_W+OFF_W-1:OFF_W];
            op_q  <= req_op;
            wp_q  <= write_policy;
            rp_q  <= replace_policy;
        end
    end

    // Register the lookup result for use in the response cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_q     <= 1'b0;
            hit_way_q <= '0;
        end else if (state == LOOKUP) begin
            hit_q     <= |hit_vec;
            hit_way_q <= hit_enc;
        end
    end

    // Valid and dirty bits: allocate on fill, mark dirty on a write-back-mode write hit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < SETS; s++) begin
                valid_arr[s] <= '0;
                dirty_arr[s] <= '0;
            end
        end else if (do_fill) begin
            valid_arr[idx_q][victim_way] <= 1'b1;
            dirty_arr[idx_q][victim_way] <= is_wr;
        end else if (do_touch && is_wr && wp_q == WP_WB) begin
            dirty_arr[idx_q][hit_way_q] <= 1'b1;
        end
    end

    // Tag storage needs no reset; valid bits qualify every entry.
    always_ff @(posedge clk) begin
        if (do_fill) tag_arr[idx_q][victim_way] <= tag_q;
    end

    // Registered response, next-level strobes and saturating statistics.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid      <= 1'b0;
            rsp_hit        <= 1'b0;
            rsp_err        <= 1'b0;
            mem_rd_valid   <= 1'b0;
            mem_rd_addr    <= '0;
            mem_wr_valid   <= 1'b0;
            wb_valid       <= 1'b0;
            wb_addr        <= '0;
            num_reads      <= '0;
            num_writes     <= '0;
            num_hits       <= '0;
            num_misses     <= '0;
            num_writebacks <= '0;
        end else begin
            rsp_valid    <= 1'b0;
            rsp_hit      <= 1'b0;
            rsp_err      <= 1'b0;
            mem_rd_valid <= 1'b0;
            mem_wr_valid <= 1'b0;
            wb_valid     <= 1'b0;
            if (state == RESP) begin
                rsp_valid    <= 1'b1;
                rsp_hit      <= hit_q && !op_err;
                rsp_err      <= op_err;
                mem_rd_valid <= do_fill;
                mem_rd_addr  <= {tag_q, idx_q, {OFF_W{1'b0}}};
                mem_wr_valid <= is_wr && (wp_q == WP_WT);
                wb_valid     <= do_wb;
                wb_addr      <= {tag_arr[idx_q][victim_way], idx_q, {OFF_W{1'b0}}};
                if (is_rd) num_reads  <= sat_inc(num_reads);
                if (is_wr) num_writes <= sat_inc(num_writes);
                if (!op_err && hit_q)  num_hits   <= sat_inc(num_hits);
                if (!op_err && !hit_q) num_misses <= sat_inc(num_misses);
                if (do_wb) num_writebacks <= sat_inc(num_writebacks);
            end
        end
    end

endmodule

// File: tb/tb_cache_level.sv
// tb/tb_cache_level.sv - randomized and directed self-checking bench for cache_level
module tb_cache_level;

    localparam logic [7:0] OPR = 8'h52;
    localparam logic [7:0] OPW = 8'h57;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        write_policy;
    logic        replace_policy;
    logic        req_valid;
    logic [47:0] req_addr;
    logic [7:0]  req_op;

    logic        req_ready, rsp_valid, rsp_hit, rsp_err, mem_rd_valid, mem_wr_valid, wb_valid;
    logic [47:0] mem_rd_addr, wb_addr;
    logic [11:0] num_reads, num_writes, num_hits, num_misses, num_writebacks;
    logic [35:0] curr_tag;
    logic [5:0]  curr_set;

    logic        s_req_ready, s_rsp_valid, s_rsp_hit, s_rsp_err, s_mem_rd_valid, s_mem_wr_valid, s_wb_valid;
    logic [47:0] s_mem_rd_addr, s_wb_addr;
    logic [3:0]  s_num_reads, s_num_writes, s_num_hits, s_num_misses, s_num_writebacks;
    logic [35:0] s_curr_tag;
    logic [5:0]  s_curr_set;

    cache_level dut (
        .clk(clk), .reset(reset), .write_policy(write_policy), .replace_policy(replace_policy),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_op(req_op),
        .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_err(rsp_err),
        .mem_rd_valid(mem_rd_valid), .mem_rd_addr(mem_rd_addr), .mem_wr_valid(mem_wr_valid),
        .wb_valid(wb_valid), .wb_addr(wb_addr),
        .num_reads(num_reads), .num_writes(num_writes), .num_hits(num_hits),
        .num_misses(num_misses), .num_writebacks(num_writebacks),
        .curr_tag(curr_tag), .curr_set(curr_set)
    );

    cache_level #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .write_policy(write_policy), .replace_policy(replace_policy),
        .req_valid(req_valid), .req_ready(s_req_ready), .req_addr(req_addr), .req_op(req_op),
        .rsp_valid(s_rsp_valid), .rsp_hit(s_rsp_hit), .rsp_err(s_rsp_err),
        .mem_rd_valid(s_mem_rd_valid), .mem_rd_addr(s_mem_rd_addr), .mem_wr_valid(s_mem_wr_valid),
        .wb_valid(s_wb_valid), .wb_addr(s_wb_addr),
        .num_reads(s_num_reads), .num_writes(s_num_writes), .num_hits(s_num_hits),
        .num_misses(s_num_misses), .num_writebacks(s_num_writebacks),
        .curr_tag(s_curr_tag), .curr_set(s_curr_set)
    );

    // Reference model: per-set lines with last-use timestamps and a FIFO fill counter.
    bit          m_valid [64][4];
    bit          m_dirty [64][4];
    logic [35:0] m_tag   [64][4];
    int          m_stamp [64][4];
    int          m_ptr   [64];
    int          m_time;
    int          m_reads, m_writes, m_hits, m_misses, m_wbs;

    logic [4:0]  exp_flags;
    logic [47:0] exp_rd_addr, exp_wb_addr;
    logic [4:0]  got_flags;
    logic [47:0] got_rd_addr, got_wb_addr;
    int          got_lat;
    logic        got_after;

    int errors = 0;
    int checks = 0;

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    function automatic logic [59:0] exp_counters();
        return {12'(sat(m_reads, 4095)), 12'(sat(m_writes, 4095)), 12'(sat(m_hits, 4095)),
                12'(sat(m_misses, 4095)), 12'(sat(m_wbs, 4095))};
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 64; s++) begin
            m_ptr[s] = 0;
            for (int w = 0; w < 4; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
                m_tag[s][w]   = '0;
                m_stamp[s][w] = 0;
            end
        end
        m_time = 0;
        m_reads = 0; m_writes = 0; m_hits = 0; m_misses = 0; m_wbs = 0;
    endtask

    // Predicts {hit, err, rd, wr, wb} and addresses, then applies the access to the model.
    task automatic model_access(input logic [47:0] a, input logic [7:0] op, input logic wp, input logic rp);
        int s, hw, v;
        logic [35:0] t;
        bit hit, alloc;
        s = int'(a[11:6]);
        t = a[47:12];
        exp_flags   = '0;
        exp_rd_addr = {a[47:6], 6'b0};
        exp_wb_addr = '0;
        if (op != OPR && op != OPW) begin
            exp_flags[3] = 1'b1;
            return;
        end
        if (op == OPR) m_reads++; else m_writes++;
        hit = 1'b0;
        hw  = 0;
        for (int w = 0; w < 4; w++) begin
            if (m_valid[s][w] && m_tag[s][w] == t) begin
                hit = 1'b1;
                hw  = w;
            end
        end
        m_time++;
        if (hit) begin
            m_hits++;
            exp_flags[4] = 1'b1;
            m_stamp[s][hw] = m_time;
            if (op == OPW && !wp) m_dirty[s][hw] = 1'b1;
        end else begin
            m_misses++;
        end
        if (op == OPW && wp) exp_flags[1] = 1'b1;
        alloc = !hit && (op == OPR || !wp);
        if (alloc) begin
            if (rp) begin
                v = -1;
                for (int w = 0; w < 4; w++) if (v < 0 && !m_valid[s][w]) v = w;
                if (v < 0) begin
                    v = 0;
                    for (int w = 1; w < 4; w++) if (m_stamp[s][w] < m_stamp[s][v]) v = w;
                end
            end else begin
                v = m_ptr[s];
            end
            m_ptr[s] = (m_ptr[s] + 1) % 4;
            exp_flags[2] = 1'b1;
            if (m_valid[s][v] && m_dirty[s][v]) begin
                exp_flags[0] = 1'b1;
                exp_wb_addr  = {m_tag[s][v], a[11:6], 6'b0};
                m_wbs++;
            end
            m_valid[s][v] = 1'b1;
            m_tag[s][v]   = t;
            m_dirty[s][v] = (op == OPW);
            m_stamp[s][v] = m_time;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    // Issues one request, predicts it, and captures the response for the caller to judge.
    task automatic do_req(input logic [47:0] a, input logic [7:0] op);
        int n;
        model_access(a, op, write_policy, replace_policy);
        @(negedge clk);
        req_addr  = a;
        req_op    = op;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 10);
        got_lat     = n;
        got_flags   = {rsp_hit, rsp_err, mem_rd_valid, mem_wr_valid, wb_valid};
        got_rd_addr = mem_rd_addr;
        got_wb_addr = wb_addr;
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL rsp_timeout: rsp_valid=%b after %0d cycles, required 1", rsp_valid, n);
        end
        @(negedge clk);
        got_after = rsp_valid | mem_rd_valid | mem_wr_valid | wb_valid;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({req_ready, rsp_valid, rsp_hit, rsp_err, mem_rd_valid, mem_wr_valid, wb_valid} !== 7'b1000000) begin
            errors++;
            $display("FAIL reset_strobes: got %b required 1000000",
                     {req_ready, rsp_valid, rsp_hit, rsp_err, mem_rd_valid, mem_wr_valid, wb_valid});
        end
        checks++;
        if ({num_reads, num_writes, num_hits, num_misses, num_writebacks} !== 60'd0) begin
            errors++;
            $display("FAIL reset_counters: got %h required 0",
                     {num_reads, num_writes, num_hits, num_misses, num_writebacks});
        end
        checks++;
        if ({curr_tag, curr_set} !== 42'd0) begin
            errors++;
            $display("FAIL reset_curr: got %h required 0", {curr_tag, curr_set});
        end
    endtask

    task automatic test_cold_write();
        do_reset();
        write_policy = 1'b0;
        replace_policy = 1'b1;
        do_req(48'h7fff493822b8, OPW);
        checks++;
        if (got_flags !== 5'b00100) begin
            errors++;
            $display("FAIL cold_write_flags: got %b required 00100", got_flags);
        end
        checks++;
        if (got_rd_addr !== 48'h7fff49382280) begin
            errors++;
            $display("FAIL cold_write_rd_addr: got %h required 7fff49382280", got_rd_addr);
        end
        checks++;
        if (got_lat !== 3) begin
            errors++;
            $display("FAIL latency: got %0d required 3", got_lat);
        end
        checks++;
        if (got_after !== 1'b0) begin
            errors++;
            $display("FAIL strobe_width: strobes still high %b required 0", got_after);
        end
        checks++;
        if ({curr_tag, curr_set} !== {36'h7fff49382, 6'd10}) begin
            errors++;
            $display("FAIL curr_tag_set: got %h/%0d required 7fff49382/10", curr_tag, curr_set);
        end
        do_req(48'h7fff493822b0, OPW);
        checks++;
        if (got_flags !== 5'b10000) begin
            errors++;
            $display("FAIL warm_write_flags: got %b required 10000", got_flags);
        end
        checks++;
        if ({num_writes, num_hits, num_misses} !== {12'd2, 12'd1, 12'd1}) begin
            errors++;
            $display("FAIL cold_write_counters: got w=%0d h=%0d m=%0d required 2/1/1",
                     num_writes, num_hits, num_misses);
        end
    endtask

    // Fill tags 1-4 in set 10, re-read tag 1, then probe tags 5, 2, 1.
    task automatic test_replacement(input logic rp, input logic [2:0] want_hits);
        logic [2:0] got_hits;
        do_reset();
        write_policy = 1'b0;
        replace_policy = rp;
        for (int t = 1; t <= 4; t++) do_req({36'(t), 12'h280}, OPR);
        do_req({36'd1, 12'h280}, OPR);
        checks++;
        if (got_flags[4] !== 1'b1) begin
            errors++;
            $display("FAIL repl%0d_rehit: hit=%b required 1", rp, got_flags[4]);
        end
        do_req({36'd5, 12'h280}, OPR);
        got_hits[2] = got_flags[4];
        do_req({36'd2, 12'h280}, OPR);
        got_hits[1] = got_flags[4];
        checks++;
        if (got_flags !== exp_flags) begin
            errors++;
            $display("FAIL repl%0d_model: got %b required %b", rp, got_flags, exp_flags);
        end
        do_req({36'd1, 12'h280}, OPR);
        got_hits[0] = got_flags[4];
        checks++;
        if (got_hits !== want_hits) begin
            errors++;
            $display("FAIL repl%0d_probe_hits: got %b required %b", rp, got_hits, want_hits);
        end
    endtask

    task automatic test_dirty_evict();
        do_reset();
        write_policy = 1'b0;
        replace_policy = 1'b1;
        for (int t = 1; t <= 4; t++) do_req({36'(t), 12'h280}, OPW);
        do_req({36'd5, 12'h280}, OPR);
        checks++;
        if (got_flags !== 5'b00101) begin
            errors++;
            $display("FAIL evict_flags: got %b required 00101", got_flags);
        end
        checks++;
        if (got_wb_addr !== 48'h000000001280) begin
            errors++;
            $display("FAIL evict_wb_addr: got %h required 000000001280", got_wb_addr);
        end
        checks++;
        if (num_writebacks !== 12'd1) begin
            errors++;
            $display("FAIL evict_count: got %0d required 1", num_writebacks);
        end
    endtask

    task automatic test_write_through();
        do_reset();
        write_policy = 1'b1;
        replace_policy = 1'b1;
        do_req(48'h0000006324d8, OPW);
        checks++;
        if (got_flags !== 5'b00010) begin
            errors++;
            $display("FAIL wt_write_flags: got %b required 00010", got_flags);
        end
        do_req(48'h0000006324d8, OPR);
        checks++;
        if (got_flags !== 5'b00100) begin
            errors++;
            $display("FAIL wt_read_flags: got %b required 00100", got_flags);
        end
    endtask

    task automatic test_error();
        do_req(48'h0000006324d8, 8'h41);
        checks++;
        if (got_flags !== 5'b01000) begin
            errors++;
            $display("FAIL err_flags: got %b required 01000", got_flags);
        end
        checks++;
        if ({num_reads, num_writes, num_hits, num_misses, num_writebacks} !== exp_counters()) begin
            errors++;
            $display("FAIL err_counters: got %h required %h",
                     {num_reads, num_writes, num_hits, num_misses, num_writebacks}, exp_counters());
        end
    endtask

    task automatic test_handshake();
        logic [1:0] busy;
        logic       extra;
        model_access(48'h0000000002c0, OPR, write_policy, replace_policy);
        @(negedge clk);
        req_addr  = 48'h0000000002c0;
        req_op    = OPR;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        busy[1] = req_ready;
        @(negedge clk);
        busy[0] = req_ready;
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if ({busy, rsp_valid} !== 3'b001) begin
            errors++;
            $display("FAIL hold_ready: got ready=%b rsp=%b required 00/1", busy, rsp_valid);
        end
        extra = 1'b0;
        repeat (4) begin
            @(negedge clk);
            extra |= rsp_valid;
        end
        checks++;
        if (extra !== 1'b0 || num_reads !== 12'(sat(m_reads, 4095))) begin
            errors++;
            $display("FAIL hold_single_accept: extra_rsp=%b reads=%0d required 0/%0d",
                     extra, num_reads, m_reads);
        end
    endtask

    task automatic test_reset_mid();
        logic seen;
        @(negedge clk);
        req_addr  = 48'h0000000002c0;
        req_op    = OPR;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        reset = 1'b0;
        #1;
        checks++;
        if ({req_ready, rsp_valid} !== 2'b10) begin
            errors++;
            $display("FAIL midreset_async: ready/rsp=%b required 10", {req_ready, rsp_valid});
        end
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            seen |= rsp_valid;
        end
        checks++;
        if (seen !== 1'b0 || {num_reads, num_writes, num_hits, num_misses, num_writebacks} !== 60'd0) begin
            errors++;
            $display("FAIL midreset_discard: rsp_seen=%b counters=%h required 0/0",
                     seen, {num_reads, num_writes, num_hits, num_misses, num_writebacks});
        end
    endtask

    task automatic test_saturation();
        do_reset();
        write_policy = 1'b0;
        replace_policy = 1'b1;
        for (int i = 0; i < 20; i++) do_req(48'h7fff493822b8, OPR);
        checks++;
        if ({s_num_reads, s_num_hits, s_num_misses} !== {4'd15, 4'd15, 4'd1}) begin
            errors++;
            $display("FAIL saturation: got r=%0d h=%0d m=%0d required 15/15/1",
                     s_num_reads, s_num_hits, s_num_misses);
        end
        checks++;
        if (num_reads !== 12'd20) begin
            errors++;
            $display("FAIL wide_reads: got %0d required 20", num_reads);
        end
    endtask

    task automatic test_random();
        logic [47:0] a;
        logic [7:0]  op;
        int          r;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            write_policy   = 1'($urandom_range(0, 1));
            replace_policy = 1'($urandom_range(0, 1));
            a = {36'($urandom_range(0, 5)), 6'($urandom_range(8, 10)), 6'($urandom_range(0, 63))};
            r = $urandom_range(0, 9);
            op = (r < 5) ? OPR : (r < 9) ? OPW : 8'h00;
            do_req(a, op);
            checks++;
            if (got_flags !== exp_flags) begin
                errors++;
                $display("FAIL rand_flags[%0d]: got %b required %b addr=%h op=%h", i, got_flags, exp_flags, a, op);
            end
            if (exp_flags[2]) begin
                checks++;
                if (got_rd_addr !== exp_rd_addr) begin
                    errors++;
                    $display("FAIL rand_rd_addr[%0d]: got %h required %h", i, got_rd_addr, exp_rd_addr);
                end
            end
            if (exp_flags[0]) begin
                checks++;
                if (got_wb_addr !== exp_wb_addr) begin
                    errors++;
                    $display("FAIL rand_wb_addr[%0d]: got %h required %h", i, got_wb_addr, exp_wb_addr);
                end
            end
        end
        checks++;
        if ({num_reads, num_writes, num_hits, num_misses, num_writebacks} !== exp_counters()) begin
            errors++;
            $display("FAIL rand_counters: got %h required %h",
                     {num_reads, num_writes, num_hits, num_misses, num_writebacks}, exp_counters());
        end
    endtask

    initial begin
        reset          = 1'b0;
        write_policy   = 1'b0;
        replace_policy = 1'b1;
        req_valid      = 1'b0;
        req_addr       = '0;
        req_op         = '0;
        model_reset();
        test_reset();
        test_cold_write();
        test_replacement(1'b1, 3'b001);
        test_replacement(1'b0, 3'b010);
        test_dirty_evict();
        test_write_through();
        test_error();
        test_handshake();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cache_level.md
# cache_level

Parametrised, trace-driven, set-associative cache level: accepts one address/op request at a time, performs tag lookup, applies LRU or FIFO replacement and write-back or write-through policy, and reports hit/miss, fill, write-back and write-through events plus saturating statistics counters. The block holds no data storage, only tag, valid, dirty and replacement state. It is the building block that `cache_top` instantiates once per level, with L1/L2 chained through the fill and write-back outputs.

## Interface
- `ADDR_W`, 48, request address width
- `SETS`, 64, number of sets, power of two ≥2
- `WAYS`, 4, associativity, power of two ≥1
- `BLOCK_BYTES`, 64, block size, power of two ≥4
- `CNT_W`, 12, statistics counter width
- Derived: `OFF_W=$clog2(BLOCK_BYTES)`, `IDX_W=$clog2(SETS)`, `TAG_W=ADDR_W-IDX_W-OFF_W`
- `clk` in 1: single clock; all state changes on the rising edge
- `reset` in 1: asynchronous, active-low
- `write_policy` in 1: 0 = write-back + write-allocate, 1 = write-through + no-write-allocate
- `replace_policy` in 1: 1 = LRU, 0 = FIFO
- `req_valid` / `req_ready` in/out 1: request handshake
- `req_addr` in ADDR_W: byte address
- `req_op` in 8: ASCII op, 8'h52 'R', 8'h57 'W'
- `rsp_valid` out 1: one-cycle response strobe
- `rsp_hit` out 1: hit flag, qualified by `rsp_valid`
- `rsp_err` out 1: unknown op, qualified by `rsp_valid`
- `mem_rd_valid` out 1: fill request to the next level
- `mem_rd_addr` out ADDR_W: block address of the fill, offset bits 0
- `mem_wr_valid` out 1: write-through write to the next level
- `wb_valid` / `wb_addr` out 1/ADDR_W: dirty victim write-back and its block address
- `num_reads`, `num_writes`, `num_hits`, `num_misses`, `num_writebacks` out CNT_W each: statistics counters
- `curr_tag` out TAG_W, `curr_set` out IDX_W: tag and index of the last accepted request

## Operation
- Address split: `tag = addr[ADDR_W-1:IDX_W+OFF_W]`, `index = addr[IDX_W+OFF_W-1:OFF_W]`.
- FSM states and transitions: IDLE→LOOKUP on handshake; LOOKUP→RESP always; RESP→IDLE always.
  - In IDLE, `req_ready`=1. At the handshake, the block latches addr, op and both policy inputs. Policy changes while a request is in flight have no effect on it.
  - In LOOKUP, all ways of the set are compared in parallel: hit = valid && tag match.
  - In RESP, all arrays are updated and the response plus memory strobes are driven.
- Read hit: update replacement state.
- Read miss: `mem_rd_valid`; allocate a way and install the tag clean.
- Write, WB mode:
  - Hit sets the dirty bit.
  - Miss allocates the way dirty, with `mem_rd_valid`.
- Write, WT mode:
  - Hit and miss both assert `mem_wr_valid`. The dirty bit is never set.
  - Miss does not allocate and leaves replacement state unchanged.
- Victim selection and write-back: on allocation, if the victim is valid and dirty, assert `wb_valid` with `wb_addr={victim_tag,index,OFF_W'b0}` and increment `num_writebacks`.
- LRU: per-way age of `$clog2(WAYS)` bits.
  - On allocation, the victim is the first invalid way at the lowest index, otherwise the way with the maximum age.
  - On an access or fill, every way younger than the touched way increments its age; the touched way's age becomes 0.
- FIFO: per-set pointer. Fills always go to the pointer way and the pointer increments with wrap. Hits do not touch the pointer.
- Counters: `num_reads` / `num_writes` count accepted R/W ops; `num_hits` / `num_misses` count their lookup results. All counters saturate at all-ones.
- Unknown op: `rsp_err`=1, `rsp_hit`=0; no array change and no counter change.

## Timing
- Handshake at edge N; LOOKUP occupies cycle N+1; `rsp_valid` and the `mem_*`/`wb_*` strobes are high for exactly the one cycle after edge N+2.
- Throughput: one request per 3 cycles. `req_ready`=0 in LOOKUP and RESP, and the requester holds its request.
- Outputs are registered. Reset values: all strobes 0, `req_ready`=1, counters 0, `curr_tag`/`curr_set` 0.
- Reset asserted mid-operation: FSM returns to IDLE immediately and strobes drop asynchronously. All valid/dirty bits, ages, pointers and counters clear; the in-flight request is discarded with no response.

## Structure
- `cache_pkg` contains:
  - `OP_READ`=8'h52, `OP_WRITE`=8'h57
  - `WP_WB`=0, `WP_WT`=1, `RP_FIFO`=0, `RP_LRU`=1
  - state enum `cache_state_t` {IDLE, LOOKUP, RESP}
- Sub-module `cache_repl`, parametrised by SETS/WAYS, owns the LRU ages and FIFO pointers. It exposes victim-way lookup and touch/fill update ports.
- Tag, valid and dirty arrays are flop arrays inside `cache_level`.

## Test plan
Defaults apply unless stated. Address 48'h7fff493822b8 has index 10 and tag 36'h7fff49382.
- Cold write, WB mode: W 7fff493822b8 → miss, `mem_rd_valid`, `mem_rd_addr`=48'h7fff49382280. Then W 7fff493822b0 → hit. Counters: writes=2, hits=1, misses=1.
- LRU, set 10, tags 1–4: read {tag,12'h280} for each, re-read tag 1 (hit), then read tag 5 → miss. Re-reading tag 2 misses; re-reading tag 1 hits. With `replace_policy`=0 the same sequence evicts tag 1 instead of tag 2.
- Dirty eviction: W tags 1–4 in set 10, then R tag 5 → `wb_valid`, `wb_addr`=48'h000000001280, `num_writebacks`=1.
- Write-through: `write_policy`=1, W 0000006324d8 → miss and `mem_wr_valid` with no `mem_rd_valid`. A following R of the same address → miss.
- Errors and handshake: `req_op`=8'h41 → `rsp_err`=1 with counters unchanged. `req_valid` held during LOOKUP is not accepted. Reset pulsed in LOOKUP → no `rsp_valid` and all counters 0.
- Saturation: `CNT_W`=4, 20 reads of one address → `num_reads`=15, `num_hits`=15, `num_misses`=1.
